// File: rtl/fw_tile_if.sv
// Stream interface of the Floyd-Warshall tile engine: tile words in, updated tile words out.
interface fw_tile_if;
    logic [1:0]  phase;
    logic        inhibit;
    logic [63:0] inD;
    logic        in_valid;
    logic [63:0] outD;
    logic        out_valid;

    modport master (output phase, inD, in_valid, input inhibit, outD, out_valid);
    modport slave  (input phase, inD, in_valid, output inhibit, outD, out_valid);
endinterface

// File: rtl/fw_tile_engine.sv
// Blocked Floyd-Warshall tile engine: loads 1-3 8x8 tiles, runs 8 pivot steps on tile C
// (all 64 cells in parallel per step), then streams C back out as 16 words.
module fw_tile_engine #(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic     clk,
    input  logic     reset,
    fw_tile_if.slave io
);
    typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_COMPUTE = 2'd1, ST_OUTPUT = 2'd2} state_t;
    localparam logic [W-1:0] INF = {W{1'b1}};

    // Infinity is absorbing; finite sums that reach the top code also become infinity.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (x == INF || y == INF || s >= {1'b0, INF}) return INF;
        else return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] relax(input logic [W-1:0] c, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W-1:0] s;
        s = sat_add(x, y);
        if (s < c) return s;
        else return c;
    endfunction

    state_t         state_r, state_next_s;
    logic [5:0]     wcnt_r;
    logic [2:0]     k_r;
    logic [4:0]     ocnt_r;
    logic [1:0]     phase_r;
    logic [W-1:0]   c_r [N*N];
    logic [W-1:0]   a_r [N*N];
    logic [W-1:0]   b_r [N*N];
    logic [W-1:0]   c_next_s [N*N];
    logic [W-1:0]   x_col_s [N];
    logic [W-1:0]   y_row_s [N];
    logic [4*W-1:0] outd_r;
    logic           out_valid_r;
    logic           inhibit_r;
    logic           accept_s;
    logic           last_word_s;
    logic [1:0]     phase_eff_s;
    logic [5:0]     last_idx_s;

    assign io.outD      = outd_r;
    assign io.out_valid = out_valid_r;
    assign io.inhibit   = inhibit_r;

    // Word acceptance and end-of-load detection; phase is live only on the first word.
    always_comb begin
        accept_s    = io.in_valid && !inhibit_r && (state_r == ST_LOAD);
        phase_eff_s = (wcnt_r == 6'd0) ? io.phase : phase_r;
        case (phase_eff_s)
            2'b00:   last_idx_s = 6'd15;
            2'b01:   last_idx_s = 6'd31;
            2'b10:   last_idx_s = 6'd31;
            2'b11:   last_idx_s = 6'd47;
            default: last_idx_s = 6'd15;
        endcase
        last_word_s = accept_s && (wcnt_r == last_idx_s);
    end

    // Next-state logic of the load/compute/output sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD:    if (last_word_s) state_next_s = ST_COMPUTE; else state_next_s = ST_LOAD;
            ST_COMPUTE: if (k_r == 3'd7) state_next_s = ST_OUTPUT; else state_next_s = ST_COMPUTE;
            ST_OUTPUT:  if (ocnt_r == 5'd16) state_next_s = ST_LOAD; else state_next_s = ST_OUTPUT;
            default:    state_next_s = ST_LOAD;
        endcase
    end

    // State register; inhibit covers every cycle spent outside LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_LOAD;
            inhibit_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            inhibit_r <= (state_next_s != ST_LOAD);
        end
    end

    // Pivot operands for step k: X column k and Y row k, chosen by the latched phase.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (phase_r[0]) x_col_s[i] = a_r[{3'(i), k_r}];
            else            x_col_s[i] = c_r[{3'(i), k_r}];
            case (phase_r)
                2'b10:   y_row_s[i] = a_r[{k_r, 3'(i)}];
                2'b11:   y_row_s[i] = b_r[{k_r, 3'(i)}];
                default: y_row_s[i] = c_r[{k_r, 3'(i)}];
            endcase
        end
    end

    // One relaxation step over all 64 cells, reading only the previous step's C.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_next_s[{3'(i), 3'(j)}] = relax(c_r[{3'(i), 3'(j)}], x_col_s[i], y_row_s[j]);
            end
        end
    end

    // Datapath: tile loading, compute steps and the output stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_r      <= 6'd0;
            k_r         <= 3'd0;
            ocnt_r      <= 5'd0;
            phase_r     <= 2'd0;
            outd_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    k_r         <= 3'd0;
                    ocnt_r      <= 5'd0;
                    out_valid_r <= 1'b0;
                    if (accept_s) begin
                        if (wcnt_r == 6'd0) phase_r <= io.phase;
                        wcnt_r <= last_word_s ? 6'd0 : wcnt_r + 6'd1;
                        // Word index within a tile maps straight onto {row, column-high-bit}.
                        for (int l = 0; l < 4; l++) begin
                            case (wcnt_r[5:4])
                                2'd0:    c_r[{wcnt_r[3:0], 2'(l)}] <= io.inD[l*W +: W];
                                2'd1:    a_r[{wcnt_r[3:0], 2'(l)}] <= io.inD[l*W +: W];
                                2'd2:    b_r[{wcnt_r[3:0], 2'(l)}] <= io.inD[l*W +: W];
                                default: ;
                            endcase
                        end
                    end
                end
                ST_COMPUTE: begin
                    c_r <= c_next_s;
                    k_r <= k_r + 3'd1;
                end
                ST_OUTPUT: begin
                    if (ocnt_r != 5'd16) begin
                        for (int l = 0; l < 4; l++) outd_r[l*W +: W] <= c_r[{ocnt_r[3:0], 2'(l)}];
                        out_valid_r <= 1'b1;
                        ocnt_r      <= ocnt_r + 5'd1;
                    end else begin
                        out_valid_r <= 1'b0;
                        ocnt_r      <= 5'd0;
                    end
                end
                default: begin
                    wcnt_r      <= 6'd0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fw_tile_engine.sv
// Directed bench for fw_tile_engine: hand-derived result tiles for each phase, latency and flow control.
module tb_fw_tile_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fw_tile_if io ();
    fw_tile_engine #(.W(16), .N(8)) dut (.clk(clk), .reset(reset), .io(io.slave));

    int checks = 0;
    int errors = 0;
    logic [15:0] tc [64];
    logic [15:0] ta [64];
    logic [15:0] tbt [64];
    logic [15:0] te [64];
    logic [63:0] wq [48];
    logic [63:0] ew [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] t [64], input int w);
        return {t[w*4+3], t[w*4+2], t[w*4+1], t[w*4]};
    endfunction

    task automatic set_tiles(input logic [15:0] cv, input logic [15:0] av, input logic [15:0] bv);
        for (int i = 0; i < 64; i++) begin
            tc[i] = cv; ta[i] = av; tbt[i] = bv; te[i] = cv;
        end
    endtask

    task automatic set_diag0();
        for (int i = 0; i < 8; i++) begin
            tc[i*9] = 16'h0000; te[i*9] = 16'h0000;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " outD"}, io.outD, 64'd0);
        check({tag, " out_valid"}, 64'(io.out_valid), 64'd0);
        check({tag, " inhibit"}, 64'(io.inhibit), 64'd0);
    endtask

    // Loads the tiles for phase ph, collects 16 output words and checks latency and handoff.
    task automatic run(input logic [1:0] ph, input bit gaps, input bit junk, input string name);
        int nw, idx, got, lat;
        bit acc;
        nw = (ph == 2'b00) ? 16 : (ph == 2'b11) ? 48 : 32;
        for (int w = 0; w < 16; w++) begin
            wq[w] = pack(tc, w); wq[16+w] = pack(ta, w); wq[32+w] = pack(tbt, w);
            ew[w] = pack(te, w);
        end
        idx = 0; got = 0; lat = -1;
        io.phase = ph;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            if (idx < nw) begin
                if (gaps && (cyc % 7) >= 4) io.in_valid = 1'b0;
                else begin
                    io.in_valid = 1'b1; io.inD = wq[idx];
                end
            end else if (junk) begin
                io.in_valid = 1'b1; io.inD = 64'hDEAD_0BAD_F00D_0000 + 64'(cyc);
            end else begin
                io.in_valid = 1'b0;
            end
            acc = io.in_valid && !io.inhibit;
            @(posedge clk); #1;
            if (acc && idx < nw) begin
                idx++;
                if (idx == 1) io.phase = ~ph;
                if (idx == nw) begin
                    lat = 0;
                    check({name, " inhibit_rise"}, 64'(io.inhibit), 64'd1);
                end
            end else if (lat >= 0) begin
                lat++;
            end
            if (io.out_valid) begin
                if (got == 0) check({name, " latency"}, 64'(lat), 64'd9);
                check($sformatf("%s word%0d", name, got), io.outD, ew[got]);
                got++;
            end
        end
        io.in_valid = 1'b0;
        check({name, " out_count"}, 64'(got), 64'd16);
        @(posedge clk); #1;
        check({name, " inhibit_fall"}, 64'(io.inhibit), 64'd0);
        check({name, " valid_fall"}, 64'(io.out_valid), 64'd0);
        check({name, " outD_hold"}, io.outD, ew[15]);
    endtask

    initial begin
        io.in_valid = 1'b0; io.inD = 64'd0; io.phase = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("reset");

        // A partial load aborted by reset must leave no trace in the next operation.
        io.phase = 2'b11;
        for (int i = 0; i < 5; i++) begin
            io.in_valid = 1'b1; io.inD = 64'h1234_5678_9ABC_0000 + 64'(i);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("reset_midload");

        set_tiles(16'hFFFF, 16'h0001, 16'h0002);
        for (int i = 0; i < 64; i++) te[i] = 16'h0003;
        run(2'b11, 1'b0, 1'b0, "broadcast");

        set_tiles(16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_diag0();
        tc[1] = 16'h0005; te[1] = 16'h0005;
        tc[10] = 16'h0003; te[10] = 16'h0003;
        te[2] = 16'h0008;
        run(2'b00, 1'b0, 1'b0, "ph00_closure");

        set_tiles(16'h0010, 16'hFFF0, 16'h0020);
        run(2'b11, 1'b0, 1'b0, "saturate");
        set_tiles(16'h0010, 16'h0008, 16'h0008);
        run(2'b11, 1'b0, 1'b0, "tie");

        // P[0][1]=4 reaches C[0][1] in both phases through the zero diagonal of C.
        set_tiles(16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_diag0();
        ta[1] = 16'h0004; te[1] = 16'h0004;
        run(2'b01, 1'b0, 1'b0, "ph01_p01");
        run(2'b10, 1'b0, 1'b0, "ph10_p01");

        // P[0][2]=5 with C[2][3]=2: only the row-pivot phase chains through C to reach C[0][3].
        set_tiles(16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_diag0();
        tc[19] = 16'h0002; te[19] = 16'h0002;
        ta[2] = 16'h0005;
        te[2] = 16'h0005; te[3] = 16'h0007;
        run(2'b01, 1'b0, 1'b0, "ph01_asym");
        te[3] = 16'hFFFF;
        run(2'b10, 1'b0, 1'b0, "ph10_asym");

        set_tiles(16'hFFFF, 16'h0001, 16'h0002);
        for (int i = 0; i < 64; i++) te[i] = 16'h0003;
        run(2'b11, 1'b1, 1'b1, "flow_ctrl");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
